siggen_multi: RTL

SIGGEN_MULTI -- requirements
Module: siggen_multi

---
 rtl/siggen_pkg.sv | 15 +
 rtl/siggen_chan.sv | 151 +++++++++++++++
 rtl/siggen_multi.sv | 57 +++++
 3 files changed

// File: rtl/siggen_pkg.sv
// Shared definitions for the multi-channel square-wave generator.
//   state_e      : per-channel FSM state
//   DEFAULT_HALF : half-period loaded at reset (3125 Hz at 100 MHz)
package siggen_pkg;

   localparam int unsigned DEFAULT_HALF = 16000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/siggen_chan.sv
// One square-wave channel: low phase first, then high; a period ends on the
// falling toggle, which is also where new settings and burst counting apply.
// Ports:
//   sysclk, reset            : clock, synchronous active-high reset
//   wr_valid_i               : decoded write strobe for this channel
//   wr_half_i / wr_burst_i   : half-period in cycles / burst length (0 = endless)
//   ch_en_i                  : level enable
//   sigout_o, busy_o         : waveform, high in RUN/STOP
//   burst_done_o             : one-cycle pulse together with the final fall
module siggen_chan #(
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned BURST_W      = 16,
   parameter int unsigned DEFAULT_HALF = 16000
) (
   input  logic               sysclk,
   input  logic               reset,
   input  logic               wr_valid_i,
   input  logic [CNT_W-1:0]   wr_half_i,
   input  logic [BURST_W-1:0] wr_burst_i,
   input  logic               ch_en_i,
   output logic               sigout_o,
   output logic               busy_o,
   output logic               burst_done_o
);
   import siggen_pkg::*;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     act_half_q, act_half_d;
   logic [CNT_W-1:0]     pend_half_q, pend_half_d;
   logic [BURST_W-1:0]   per_q, per_d;
   logic [BURST_W-1:0]   act_burst_q, act_burst_d;
   logic [BURST_W-1:0]   pend_burst_q, pend_burst_d;
   logic                 sig_q, sig_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [CNT_W-1:0]     src_half;
   logic [BURST_W-1:0]   src_burst;
   logic [BURST_W-1:0]   per_inc;
   logic                 at_end, fall_tgl, rise_tgl, burst_hit;

   // Pending settings with a same-cycle write bypassed, so a write that lands
   // on a falling toggle (or in IDLE/DONE) is used at that very edge.
   always_comb begin
      src_half  = wr_valid_i ? wr_half_i  : pend_half_q;
      src_burst = wr_valid_i ? wr_burst_i : pend_burst_q;
      at_end    = (cnt_q == act_half_q - CNT_W'(1));
      fall_tgl  = at_end && sig_q;
      rise_tgl  = at_end && !sig_q;
      per_inc   = per_q + BURST_W'(1);
      burst_hit = (act_burst_q != '0) && (per_inc >= act_burst_q);
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sig_d        = sig_q;
      per_d        = per_q;
      act_half_d   = act_half_q;
      act_burst_d  = act_burst_q;
      pend_half_d  = src_half;
      pend_burst_d = src_burst;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            act_half_d  = src_half;
            act_burst_d = src_burst;
            sig_d       = 1'b0;
            cnt_d       = '0;
            per_d       = '0;
            if (ch_en_i) state_d = RUN;
         end
         DONE: begin
            act_half_d  = src_half;
            act_burst_d = src_burst;
            sig_d       = 1'b0;
            if (!ch_en_i) state_d = IDLE;
         end
         RUN, STOP: begin
            if (fall_tgl) begin
               // Period boundary: settings swap here so no partial period occurs.
               sig_d       = 1'b0;
               cnt_d       = '0;
               per_d       = per_inc;
               act_half_d  = src_half;
               act_burst_d = src_burst;
               if (burst_hit) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (!ch_en_i) begin
                  state_d = IDLE;
               end else begin
                  state_d = RUN;
               end
            end else if (rise_tgl) begin
               cnt_d = '0;
               if (ch_en_i) begin
                  sig_d   = 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // A disable during the high phase waits for the fall (no runt).
               if (ch_en_i)     state_d = RUN;
               else if (!sig_q) state_d = IDLE;
               else             state_d = STOP;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == STOP);
   end

   // State and output registers.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         per_q        <= '0;
         act_half_q   <= CNT_W'(DEFAULT_HALF);
         pend_half_q  <= CNT_W'(DEFAULT_HALF);
         act_burst_q  <= '0;
         pend_burst_q <= '0;
         sig_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         per_q        <= per_d;
         act_half_q   <= act_half_d;
         pend_half_q  <= pend_half_d;
         act_burst_q  <= act_burst_d;
         pend_burst_q <= pend_burst_d;
         sig_q        <= sig_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign sigout_o     = sig_q;
   assign busy_o       = busy_q;
   assign burst_done_o = done_q;

endmodule

// File: rtl/siggen_multi.sv
// Multi-channel square-wave generator top: decodes configuration writes and
// fans them out to CHANNELS independent siggen_chan instances.
// Ports:
//   sysclk, reset                 : clock, synchronous active-high reset
//   wr_en, wr_ch, wr_half, wr_burst : configuration write (dropped if half==0
//                                   or channel out of range)
//   ch_en                         : per-channel enable
//   sigout, busy, burst_done      : per-channel registered outputs
module siggen_multi #(
   parameter  int unsigned CHANNELS     = 4,
   parameter  int unsigned CNT_W        = 24,
   parameter  int unsigned BURST_W      = 16,
   parameter  int unsigned DEFAULT_HALF = siggen_pkg::DEFAULT_HALF,
   localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                sysclk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [CNT_W-1:0]    wr_half,
   input  logic [BURST_W-1:0]  wr_burst,
   input  logic [CHANNELS-1:0] ch_en,
   output logic [CHANNELS-1:0] sigout,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] burst_done
);
   import siggen_pkg::*;

   logic [CHANNELS-1:0] wr_hit;

   // Write decode; an out-of-range channel matches no instance and is dropped.
   always_comb begin
      wr_hit = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         wr_hit[c] = wr_en && (wr_half != '0) && (32'(wr_ch) == c);
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      siggen_chan #(
         .CNT_W        (CNT_W),
         .BURST_W      (BURST_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_chan (
         .sysclk       (sysclk),
         .reset        (reset),
         .wr_valid_i   (wr_hit[g]),
         .wr_half_i    (wr_half),
         .wr_burst_i   (wr_burst),
         .ch_en_i      (ch_en[g]),
         .sigout_o     (sigout[g]),
         .busy_o       (busy[g]),
         .burst_done_o (burst_done[g])
      );
   end

endmodule
